// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side monitor for a Fibonacci LFSR stream.
// Captures a reference state, checks every subsequent step against the
// predicted next state, measures the recurrence period and reports
// lock-up, mismatch and timeout conditions. All outputs are registered.
module lfsr_checker #(
    parameter int            W    = 8,
    parameter logic [W-1:0]  TAPS = 8'hB8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] lfsr_in,
    input  logic         in_valid,
    output logic         busy,
    output logic         done,
    output logic [W:0]   period,
    output logic         maximal,
    output logic         mismatch,
    output logic [7:0]   err_count,
    output logic         lockup,
    output logic         timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Step count at which the run gives up (2^W) and the maximal period (2^W-1).
    localparam logic [W:0] CNT_LIMIT  = {1'b1, {W{1'b0}}};
    localparam logic [W:0] MAX_PERIOD = {1'b0, {W{1'b1}}};
    localparam logic [W:0] CNT_ONE    = {{W{1'b0}}, 1'b1};

    // Predicted successor: shift left, parity of tapped bits into bit 0.
    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] cur);
        return {cur[W-2:0], ^(cur & TAPS)};
    endfunction

    state_t       state_r,     state_next_s;
    logic [W-1:0] ref_r,       ref_next_s;
    logic [W-1:0] prev_r,      prev_next_s;
    logic [W:0]   cnt_r,       cnt_next_s;
    logic [W:0]   period_r,    period_next_s;
    logic         maximal_r,   maximal_next_s;
    logic         mismatch_r,  mismatch_next_s;
    logic [7:0]   err_count_r, err_count_next_s;
    logic         lockup_r,    lockup_next_s;
    logic         timeout_r,   timeout_next_s;
    logic         busy_r,      busy_next_s;
    logic         done_r,      done_next_s;

    logic [W:0]   cnt_inc_s;
    logic         step_bad_s;
    logic         sticky_mis_s;

    // Next-state and next-result computation for the measurement FSM.
    always_comb begin
        state_next_s     = state_r;
        ref_next_s       = ref_r;
        prev_next_s      = prev_r;
        cnt_next_s       = cnt_r;
        period_next_s    = period_r;
        maximal_next_s   = maximal_r;
        mismatch_next_s  = mismatch_r;
        err_count_next_s = err_count_r;
        lockup_next_s    = lockup_r;
        timeout_next_s   = timeout_r;

        cnt_inc_s    = cnt_r + CNT_ONE;
        step_bad_s   = (lfsr_in != lfsr_next(prev_r));
        sticky_mis_s = mismatch_r | step_bad_s;

        if (start) begin
            // Start always (re)arms and discards any concurrent sample.
            state_next_s     = ST_ARM;
            period_next_s    = {(W+1){1'b0}};
            maximal_next_s   = 1'b0;
            mismatch_next_s  = 1'b0;
            err_count_next_s = 8'd0;
            lockup_next_s    = 1'b0;
            timeout_next_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_IDLE;
                end
                ST_ARM: begin
                    if (in_valid) begin
                        ref_next_s  = lfsr_in;
                        prev_next_s = lfsr_in;
                        cnt_next_s  = {(W+1){1'b0}};
                        if (lfsr_in == {W{1'b0}}) begin
                            state_next_s   = ST_DONE;
                            lockup_next_s  = 1'b1;
                            period_next_s  = {(W+1){1'b0}};
                            maximal_next_s = 1'b0;
                        end else begin
                            state_next_s = ST_RUN;
                        end
                    end else begin
                        state_next_s = ST_ARM;
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        // Resynchronise to the received value, good or bad.
                        prev_next_s = lfsr_in;
                        cnt_next_s  = cnt_inc_s;
                        if (step_bad_s) begin
                            mismatch_next_s = 1'b1;
                            if (err_count_r != 8'hFF) begin
                                err_count_next_s = err_count_r + 8'd1;
                            end else begin
                                err_count_next_s = err_count_r;
                            end
                        end else begin
                            mismatch_next_s = mismatch_r;
                        end
                        if (lfsr_in == ref_r) begin
                            state_next_s   = ST_DONE;
                            period_next_s  = cnt_inc_s;
                            maximal_next_s = (cnt_inc_s == MAX_PERIOD) && !sticky_mis_s;
                        end else if (cnt_inc_s == CNT_LIMIT) begin
                            state_next_s   = ST_DONE;
                            timeout_next_s = 1'b1;
                            period_next_s  = {(W+1){1'b0}};
                            maximal_next_s = 1'b0;
                        end else begin
                            state_next_s = ST_RUN;
                        end
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_next_s = ST_DONE;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end

        busy_next_s = (state_next_s == ST_ARM) || (state_next_s == ST_RUN);
        done_next_s = (state_next_s == ST_DONE);
    end

    // State, datapath and registered outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ref_r       <= {W{1'b0}};
            prev_r      <= {W{1'b0}};
            cnt_r       <= {(W+1){1'b0}};
            period_r    <= {(W+1){1'b0}};
            maximal_r   <= 1'b0;
            mismatch_r  <= 1'b0;
            err_count_r <= 8'd0;
            lockup_r    <= 1'b0;
            timeout_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            ref_r       <= ref_next_s;
            prev_r      <= prev_next_s;
            cnt_r       <= cnt_next_s;
            period_r    <= period_next_s;
            maximal_r   <= maximal_next_s;
            mismatch_r  <= mismatch_next_s;
            err_count_r <= err_count_next_s;
            lockup_r    <= lockup_next_s;
            timeout_r   <= timeout_next_s;
            busy_r      <= busy_next_s;
            done_r      <= done_next_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign period    = period_r;
    assign maximal   = maximal_r;
    assign mismatch  = mismatch_r;
    assign err_count = err_count_r;
    assign lockup    = lockup_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_lfsr_checker.sv
// Testbench for lfsr_checker: table of directed scenarios with fixed
// expectations, hand-written reset/abort sequences, and randomized streams
// checked against a behavioural period/mismatch model.
module tb_lfsr_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] lfsr_in;
    logic       in_valid;

    logic       a_busy, a_done, a_maximal, a_mismatch, a_lockup, a_timeout;
    logic [8:0] a_period;
    logic [7:0] a_err;
    logic       b_busy, b_done, b_maximal, b_mismatch, b_lockup, b_timeout;
    logic [8:0] b_period;
    logic [7:0] b_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       done;
        logic       busy;
        int         period;
        logic       maximal;
        logic       mismatch;
        int         err;
        logic       lockup;
        logic       timeout;
    } exp_t;

    typedef struct {
        string      name;
        logic [7:0] seed;
        logic       tsel;   // 0: taps B8 instance, 1: taps 80 instance
        int         kind;   // 0 true, 1 complement #10, 2 constant 55
        exp_t       e;
    } vec_t;

    logic [7:0] stream[$];

    lfsr_checker #(.W(8), .TAPS(8'hB8)) dut_a (
        .clk(clk), .reset(reset), .start(start), .lfsr_in(lfsr_in),
        .in_valid(in_valid), .busy(a_busy), .done(a_done), .period(a_period),
        .maximal(a_maximal), .mismatch(a_mismatch), .err_count(a_err),
        .lockup(a_lockup), .timeout(a_timeout)
    );

    lfsr_checker #(.W(8), .TAPS(8'h80)) dut_b (
        .clk(clk), .reset(reset), .start(start), .lfsr_in(lfsr_in),
        .in_valid(in_valid), .busy(b_busy), .done(b_done), .period(b_period),
        .maximal(b_maximal), .mismatch(b_mismatch), .err_count(b_err),
        .lockup(b_lockup), .timeout(b_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
        end
    endtask

    // Successor of an LFSR state computed with plain arithmetic.
    function automatic logic [7:0] step(input logic [7:0] cur, input logic [7:0] taps);
        int fb;
        fb = $countones(cur & taps) % 2;
        return 8'((int'(cur) * 2 + fb) % 256);
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.done = 1'b0; e.busy = 1'b0; e.period = 0; e.maximal = 1'b0;
        e.mismatch = 1'b0; e.err = 0; e.lockup = 1'b0; e.timeout = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk_exp(input int per, input logic mx, input logic mis,
                                    input int err, input logic lk, input logic to);
        exp_t e;
        e = zero_exp();
        e.done = 1'b1; e.period = per; e.maximal = mx; e.mismatch = mis;
        e.err = err; e.lockup = lk; e.timeout = to;
        return e;
    endfunction

    task automatic check_out(input logic sel, input exp_t e, input string nm);
        if (sel) begin
            chk({nm, ".done"},     int'(b_done),     int'(e.done));
            chk({nm, ".busy"},     int'(b_busy),     int'(e.busy));
            chk({nm, ".period"},   int'(b_period),   e.period);
            chk({nm, ".maximal"},  int'(b_maximal),  int'(e.maximal));
            chk({nm, ".mismatch"}, int'(b_mismatch), int'(e.mismatch));
            chk({nm, ".err"},      int'(b_err),      e.err);
            chk({nm, ".lockup"},   int'(b_lockup),   int'(e.lockup));
            chk({nm, ".timeout"},  int'(b_timeout),  int'(e.timeout));
        end else begin
            chk({nm, ".done"},     int'(a_done),     int'(e.done));
            chk({nm, ".busy"},     int'(a_busy),     int'(e.busy));
            chk({nm, ".period"},   int'(a_period),   e.period);
            chk({nm, ".maximal"},  int'(a_maximal),  int'(e.maximal));
            chk({nm, ".mismatch"}, int'(a_mismatch), int'(e.mismatch));
            chk({nm, ".err"},      int'(a_err),      e.err);
            chk({nm, ".lockup"},   int'(a_lockup),   int'(e.lockup));
            chk({nm, ".timeout"},  int'(a_timeout),  int'(e.timeout));
        end
    endtask

    // Fill 'stream' with 300 samples of the chosen scenario kind.
    task automatic build_stream(input logic [7:0] seed, input logic [7:0] taps, input int kind);
        logic [7:0] cur;
        stream.delete();
        cur = seed;
        for (int i = 0; i < 300; i++) begin
            stream.push_back(cur);
            cur = step(cur, taps);
        end
        if (kind == 1) begin
            stream[10] = ~stream[10];
        end
        if (kind == 2) begin
            for (int i = 1; i < 300; i++) stream[i] = 8'h55;
        end
    endtask

    // Reference: first sample is the reference; run until it recurs or 256 steps pass.
    task automatic model(input logic [7:0] taps, output exp_t e, output int n);
        logic [7:0] rv, pv;
        int errs;
        e = zero_exp();
        e.done = 1'b1;
        rv = stream[0];
        n = 1;
        if (rv == 8'h00) begin
            e.lockup = 1'b1;
            return;
        end
        pv = rv;
        errs = 0;
        for (int k = 1; k < 300; k++) begin
            if (stream[k] != step(pv, taps)) errs++;
            pv = stream[k];
            if (stream[k] == rv) begin
                e.period = k;
                e.maximal = (k == 255) && (errs == 0);
                n = k + 1;
                break;
            end
            if (k == 256) begin
                e.timeout = 1'b1;
                n = k + 1;
                break;
            end
        end
        e.mismatch = (errs > 0);
        e.err = (errs > 255) ? 255 : errs;
    endtask

    // Pulse start (with a decoy sample) and present the first n stream samples.
    task automatic feed(input logic sel, input int n, input int gap_pct, input string nm);
        start = 1'b1; in_valid = 1'b1; lfsr_in = 8'hEE;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0; lfsr_in = 8'($urandom_range(0, 255));
                tick();
            end
            if (i == n - 1 && n >= 2) begin
                chk({nm, ".not_early"}, sel ? int'(b_done) : int'(a_done), 0);
            end
            in_valid = 1'b1; lfsr_in = stream[i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    vec_t vecs[5];
    exp_t em;
    int   n;

    initial begin
        vecs[0] = '{"maximal_b8", 8'h32, 1'b0, 0, mk_exp(255, 1'b1, 1'b0, 0,   1'b0, 1'b0)};
        vecs[1] = '{"rotate_80",  8'h32, 1'b1, 0, mk_exp(8,   1'b0, 1'b0, 0,   1'b0, 1'b0)};
        vecs[2] = '{"lockup",     8'h00, 1'b0, 0, mk_exp(0,   1'b0, 1'b0, 0,   1'b1, 1'b0)};
        vecs[3] = '{"corrupt10",  8'h32, 1'b0, 1, mk_exp(255, 1'b0, 1'b1, 2,   1'b0, 1'b0)};
        vecs[4] = '{"timeout",    8'h32, 1'b0, 2, mk_exp(0,   1'b0, 1'b1, 255, 1'b0, 1'b1)};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; lfsr_in = 8'h00;
        tick(); tick();
        check_out(1'b0, zero_exp(), "reset_a");
        reset = 1'b0;
        tick();
        check_out(1'b0, zero_exp(), "idle_a");

        // Directed table.
        foreach (vecs[v]) begin
            build_stream(vecs[v].seed, vecs[v].tsel ? 8'h80 : 8'hB8, vecs[v].kind);
            model(vecs[v].tsel ? 8'h80 : 8'hB8, em, n);
            feed(vecs[v].tsel, n, 0, vecs[v].name);
            check_out(vecs[v].tsel, vecs[v].e, vecs[v].name);
        end

        // Results hold after done despite further valid traffic.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; lfsr_in = 8'($urandom_range(0, 255));
            tick();
        end
        in_valid = 1'b0;
        check_out(1'b0, vecs[4].e, "hold");

        // Reset mid-run, then a fresh start with 50% valid gaps.
        build_stream(8'h32, 8'hB8, 0);
        feed(1'b0, 100, 0, "pre_reset");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_out(1'b0, zero_exp(), "mid_reset");
        feed(1'b0, 256, 50, "after_reset");
        check_out(1'b0, vecs[0].e, "after_reset");

        // Start mid-run aborts and restarts cleanly.
        feed(1'b0, 40, 0, "pre_abort");
        feed(1'b0, 256, 20, "abort");
        check_out(1'b0, vecs[0].e, "abort");

        // Reset together with start: reset wins.
        feed(1'b0, 20, 0, "pre_rs");
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        check_out(1'b0, zero_exp(), "reset_start");

        // Randomized streams against the model.
        for (int r = 0; r < 8; r++) begin
            logic       tsel;
            logic [7:0] taps;
            tsel = 1'($urandom_range(0, 1));
            taps = tsel ? 8'h80 : 8'hB8;
            build_stream(8'($urandom_range(0, 255)), taps, 0);
            for (int i = 1; i < 300; i++) begin
                if (r == 7 || $urandom_range(0, 99) < 2) stream[i] = 8'($urandom_range(0, 255));
            end
            model(taps, em, n);
            feed(tsel, n, 30, $sformatf("rand%0d", r));
            check_out(tsel, em, $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side companion to the 8-bit `lfsr` generator. It watches the generator's output stream and checks every step against the expected next state.
- It measures the sequence period, i.e. the number of steps until the first captured value recurs, and flags whether that period is maximal (2^W-1).
- It detects all-zero lock-up, step mismatches and a sequence that never repeats.
- It replaces file-dump inspection of the LFSR output with a self-checking hardware monitor that can be used in simulation and in silicon.

Parameters:
- W, 8: LFSR width in bits.
- TAPS, 8'hB8: feedback mask. The expected next state is {cur[W-2:0], ^(cur & TAPS)} (Fibonacci, shift left, feedback into bit 0). 8'hB8 is x^8+x^6+x^5+x^4+1, which is maximal.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle pulse; arms a new measurement and aborts any measurement in progress.
- lfsr_in, input, W: observed LFSR state.
- in_valid, input, 1: lfsr_in carries a new step this cycle.
- busy, output, 1: measurement in progress (ARM or RUN).
- done, output, 1: result valid; held until the next start or reset.
- period, output, W+1: measured period; 0 on lockup or timeout.
- maximal, output, 1: period == 2^W-1 with no mismatches.
- mismatch, output, 1: sticky; at least one step differed from prediction.
- err_count, output, 8: number of mismatching steps, saturating at 255.
- lockup, output, 1: captured reference was all zeros.
- timeout, output, 1: no recurrence within 2^W steps.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - State returns to IDLE.
  - All outputs are 0; ref, prev and cnt registers are 0.
- Reset mid-run abandons the measurement; there is no partial result.
- All outputs are registered.
- FSM states:
  - IDLE: busy=0. On start, go to ARM and clear done, period, maximal, mismatch, err_count, lockup and timeout in the same edge.
  - ARM: busy=1.
    - The lfsr_in sample presented in the cycle start is asserted is ignored.
    - On the first in_valid after start: ref <= lfsr_in, prev <= lfsr_in, cnt <= 0.
    - If lfsr_in == 0: go to DONE with lockup=1, period=0, maximal=0.
    - Otherwise go to RUN.
  - RUN: busy=1. On each in_valid:
    - exp = next(prev). If lfsr_in != exp: mismatch <= 1 and err_count++ (saturating).
    - prev <= lfsr_in (the checker resynchronises to the received value).
    - cnt <= cnt+1.
    - If lfsr_in == ref: go to DONE with period = cnt+1 and maximal = (cnt+1 == 2^W-1) && !mismatch_next.
    - Else if cnt+1 == 2^W: go to DONE with timeout=1, period=0, maximal=0.
    - Cycles with in_valid=0 change nothing.
  - DONE: busy=0, done=1. Results are held. start goes to ARM, clearing results as in IDLE.
- Latency: done rises on the clock edge that accepts the recurring sample, so it is visible the cycle after that sample was presented.
- Simultaneous events:
  - start in ARM or RUN: restart in ARM; the concurrent sample is ignored.
  - reset together with start: reset wins.
- Mismatch evaluation uses the stream value. A sample equal to ref ends the run even when it is also a mismatch; both flags are reported.
- cnt is W+1 bits wide and never wraps, because timeout terminates the run at 2^W.

Test Plan:
1. TAPS=8'hB8, generator seeded 8'h32, start then continuous in_valid -> done after 255 post-reference samples, period=255, maximal=1, mismatch=0, err_count=0.
2. TAPS=8'h80 (rotate), feed rotation of 8'h32 -> period=8, maximal=0, mismatch=0.
3. First sample 8'h00 -> next edge done=1, lockup=1, period=0, busy=0.
4. Run as in scenario 1, but replace sample #10 with its bitwise complement (not equal to 8'h32), then resume the true stream -> err_count=2, mismatch=1, period=255, maximal=0.
5. Samples 8'h32 then constant 8'h55 -> done after 256 samples, timeout=1, period=0, err_count=255 (saturated).
6. Reset asserted at sample #100 of scenario 1 -> next cycle all outputs 0, state IDLE. A fresh start then reproduces the scenario 1 result. Also toggle in_valid 50% and confirm identical results.
